// File: rtl/burn_sequencer.sv
// Multi-stage burn sequencer gating the velocity datapath on a divided tick.
// Optional mission tick telemetry: define BURN_SEQ_TELEMETRY_EN.
module burn_sequencer #(
  parameter int NUM_STAGES  = 2,
  parameter int TICK_DIV    = 10,
  parameter int COAST_TICKS = 5,
  parameter int W           = 64
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         start,
  input  logic         abort,
  input  logic         fault_clr,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_stage,
  input  logic [1:0]   cfg_sel,
  input  logic [W-1:0] cfg_data,
  output logic         calc_clear,
  output logic         calc_en,
  output logic [W-1:0] isp_o,
  output logic [W-1:0] init_w_o,
  output logic [W-1:0] prop_w_o,
  output logic [W-1:0] burntime_o,
  output logic [1:0]   stage_idx,
  output logic [2:0]   state_o,
  output logic [W-1:0] burn_ticks,
  output logic         sep_pulse,
  output logic         busy,
  output logic         done,
  output logic         fault,
  output logic [31:0]  mission_ticks
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (COAST_TICKS > 1) ? $clog2(COAST_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_BURN  = 3'd2,
    S_COAST = 3'd3,
    S_SEP   = 3'd4,
    S_DONE  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q;
  logic [CW-1:0]  coast_q;
  logic           armed_q;
  logic [W-1:0]   cfg_q [4][4];
  logic [1:0]     stage_q;
  logic [W-1:0]   bt_q;
  logic [W-1:0]   isp_q, init_q, prop_q, burn_q;
  logic           clr_q, en_q, sep_q;
  logic           busy_q, done_q, fault_q;

  logic running, tick, last_burn, coast_end;
  logic last_stage, bad_cfg, launch;

  assign running    = (state_q == S_BURN) || (state_q == S_COAST);
  assign tick       = running && (presc_q == PW'(TICK_DIV - 1));
  assign last_burn  = bt_q == (burn_q - W'(1));
  assign coast_end  = coast_q == CW'(COAST_TICKS - 1);
  assign last_stage = stage_q == 2'(NUM_STAGES - 1);
  assign bad_cfg    = (cfg_q[stage_q][3] == '0)
                   || (cfg_q[stage_q][2] >= cfg_q[stage_q][1])
                   || (cfg_q[stage_q][1] == '0);
  assign launch     = ((state_q == S_IDLE) || (state_q == S_DONE))
                   && (state_d == S_LOAD);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_DONE:  if (start && armed_q) state_d = S_LOAD;
      S_LOAD:  state_d = (abort || bad_cfg) ? S_FAULT : S_BURN;
      S_BURN: begin
        if (abort) state_d = S_FAULT;
        else if (tick && last_burn) state_d = S_COAST;
      end
      S_COAST: begin
        if (abort) state_d = S_FAULT;
        else if (tick && coast_end)
          state_d = last_stage ? S_DONE : S_SEP;
      end
      S_SEP:   state_d = abort ? S_FAULT : S_LOAD;
      S_FAULT: if (fault_clr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      coast_q <= '0;
      armed_q <= 1'b0;
      stage_q <= '0;
      bt_q    <= '0;
      isp_q   <= '0;
      init_q  <= '0;
      prop_q  <= '0;
      burn_q  <= '0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      sep_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      for (int s = 0; s < 4; s++)
        for (int f = 0; f < 4; f++)
          cfg_q[s][f] <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= state_d == S_LOAD;
      en_q    <= state_d == S_BURN;
      sep_q   <= state_d == S_SEP;
      busy_q  <= (state_d == S_LOAD) || (state_d == S_BURN)
              || (state_d == S_COAST) || (state_d == S_SEP);
      done_q  <= state_d == S_DONE;
      fault_q <= state_d == S_FAULT;

      if (running && (state_d == state_q))
        presc_q <= tick ? '0 : presc_q + PW'(1);
      else
        presc_q <= '0;

      if (state_q != S_COAST) coast_q <= '0;
      else if (tick) coast_q <= coast_q + CW'(1);

      // a fresh start out of DONE needs start seen low first
      if (state_q != S_DONE) armed_q <= 1'b0;
      else if (!start) armed_q <= 1'b1;

      if (cfg_we && !busy_q && ({1'b0, cfg_stage} < 3'(NUM_STAGES)))
        cfg_q[cfg_stage][cfg_sel] <= cfg_data;

      if (launch) begin
        stage_q <= '0;
        bt_q    <= '0;
      end

      if ((state_q == S_LOAD) && !abort) begin
        isp_q  <= cfg_q[stage_q][0];
        init_q <= cfg_q[stage_q][1];
        prop_q <= cfg_q[stage_q][2];
        burn_q <= cfg_q[stage_q][3];
      end

      if ((state_q == S_BURN) && (state_d != S_FAULT) && tick)
        bt_q <= bt_q + W'(1);

      if ((state_q == S_SEP) && (state_d == S_LOAD)) begin
        stage_q <= stage_q + 2'd1;
        bt_q    <= '0;
      end
    end
  end

`ifdef BURN_SEQ_TELEMETRY_EN
  logic [31:0] mission_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) mission_q <= '0;
    else if (launch) mission_q <= '0;
    else if (tick && (state_d != S_FAULT)) mission_q <= mission_q + 32'd1;
  end

  assign mission_ticks = mission_q;
`else
  assign mission_ticks = '0;
`endif

  assign calc_clear = clr_q;
  assign calc_en    = en_q;
  assign isp_o      = isp_q;
  assign init_w_o   = init_q;
  assign prop_w_o   = prop_q;
  assign burntime_o = burn_q;
  assign stage_idx  = stage_q;
  assign state_o    = state_q;
  assign burn_ticks = bt_q;
  assign sep_pulse  = sep_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;

endmodule
